multicycle_control: RTL and testbench
=====================================

# multicycle_control

Finite-state main controller for the multi-cycle RV32I datapath. It sequences each instruction through fetch, decode, execute, memory and writeback steps, and drives the shared ALU, register file, IR and PC enables. It handshakes with a single shared instruction/data memory that may stall. It adds illegal-opcode trapping and an optional memory-timeout watchdog.

## Interface

Parameters:
- TRAP_ON_ILLEGAL, 1, 1: an unknown opcode enters TRAP. 0: it is retired as a NOP.
- MEM_TIMEOUT, 0, maximum stall cycles per memory access before TRAP. 0 disables the watchdog.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- opcode  in  7  IR[6:0], valid from DECODE onward
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request
- mem_we  out  1  write strobe, valid with mem_req
- addr_src  out  1  memory address source: 0 = PC, 1 = ALUOut
- ir_write  out  1  IR load enable
- pc_write  out  1  PC load enable
- reg_write  out  1  register file write enable
- result_src  out  2  result bus source: 00 = ALUOut, 01 = memory data, 10 = ALU result direct
- alu_src_a  out  2  ALU A source: 00 = PC, 01 = oldPC, 10 = rs1, 11 = zero
- alu_src_b  out  2  ALU B source: 00 = rs2, 01 = imm, 10 = constant 4
- alu_op  out  2  00 = add, 01 = sub/compare, 10 = R-type funct, 11 = I-type funct
- branch  out  1  PC loads ALUOut if the ALU zero flag is set
- retire  out  1  one-cycle pulse as each instruction completes
- illegal  out  1  high in TRAP when the cause is an illegal opcode
- bus_err  out  1  high in TRAP when the cause is a memory timeout
- state_o  out  4  current state encoding, for debug

## Operation

- Moore outputs are decoded from the state register. The exceptions are ir_write and pc_write in FETCH, which are Mealy outputs gated by mem_ready.
- Any output not listed for a state is 0.
- State encodings and outputs:
  - FETCH (0): mem_req=1, addr_src=0, A=00, B=10, alu_op=00, result_src=10. When mem_ready=1: ir_write=1, pc_write=1, go to DECODE. Otherwise stay.
  - DECODE (1): A=01, B=01, alu_op=00, forming the branch/jal target in ALUOut. Next state by opcode:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 1100011 → BEQ
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 or 0010111 → UPPER
    - any other opcode → TRAP, or FETCH with retire=1 when TRAP_ON_ILLEGAL=0
  - MEMADR (2): A=10, B=01, alu_op=00. Load → MEMREAD, store → MEMWRITE.
  - MEMREAD (3): mem_req=1, addr_src=1. Go to MEMWB on mem_ready.
  - MEMWB (4): reg_write=1, result_src=01, retire=1. → FETCH.
  - MEMWRITE (5): mem_req=1, mem_we=1, addr_src=1. On mem_ready: retire=1, → FETCH.
  - EXEC_R (6): A=10, B=00, alu_op=10. → ALUWB.
  - EXEC_I (7): A=10, B=01, alu_op=11. → ALUWB.
  - ALUWB (8): reg_write=1, result_src=00, retire=1. → FETCH.
  - BEQ (9): A=10, B=00, alu_op=01, branch=1, result_src=00, retire=1. → FETCH.
  - JAL (10): pc_write=1, result_src=00, A=01, B=10, alu_op=00 (link computed into ALUOut). → ALUWB.
  - JALR (11): A=10, B=01, alu_op=00, result_src=10, pc_write=1. → LINK.
  - LINK (12): A=01, B=10, alu_op=00. → ALUWB.
  - UPPER (13): B=01, alu_op=00, A=11 for lui or A=01 for auipc. → ALUWB.
  - TRAP (14): illegal or bus_err held high. Stays in TRAP until reset.
- Watchdog, active only when MEM_TIMEOUT>0:
  - Counter width is $clog2(MEM_TIMEOUT+1).
  - It increments each cycle in FETCH, MEMREAD or MEMWRITE while mem_ready=0, and clears on every state change.
  - If the counter equals MEM_TIMEOUT with mem_ready=0, the next state is TRAP with bus_err=1.
  - mem_ready=1 in that same cycle wins over the timeout.
- Cause flags are registered on TRAP entry and are mutually exclusive.

## Timing

- Reset (asynchronous): state=FETCH, watchdog=0, illegal=0, bus_err=0.
- Outputs during and immediately after reset are the FETCH values: mem_req=1, A=00, B=10, result_src=10, all enables 0, state_o=0.
- With zero wait states, instruction latency is:
  - BEQ: 3 cycles
  - R-type, I-type, lui, auipc, store: 4 cycles
  - JAL: 4 cycles
  - load, JALR: 5 cycles
- Each memory stall cycle adds 1.
- mem_req stays high and the address/we stay stable until the cycle in which mem_ready=1. Exactly one ir_write or pc_write pulse occurs per FETCH.
- opcode is sampled only in DECODE and MEMADR.
- mem_ready outside memory states is ignored.

## Test plan

- Reset, then 0110011 with mem_ready always 1 → states 0,1,6,8,0. retire pulses in cycle 4, reg_write=1 only in ALUWB.
- Load (0000011), mem_ready low for 3 cycles in MEMREAD → mem_req stays high for 4 cycles, addr_src=1, then MEMWB with result_src=01. Total 8 cycles.
- Opcode 1111111 → TRAP with illegal=1, held for 20+ cycles. Repeat with TRAP_ON_ILLEGAL=0 → retire in DECODE, back to FETCH.
- MEM_TIMEOUT=4, mem_ready stuck low in FETCH → TRAP entered after the 5th stall cycle with bus_err=1. Repeat with mem_ready rising on that 5th cycle → DECODE, no trap.
- JALR then JAL → pc_write asserted in JALR and in JAL, link written in ALUWB. State sequences 0,1,11,12,8 and 0,1,10,8.
- Assert rst_n low mid-MEMWRITE → state_o=0 immediately (asynchronous), mem_we=0, mem_req=1.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Memory handshake bundle between the multi-cycle controller and the shared
// instruction/data memory.
interface multicycle_control_if;
  logic mem_req;
  logic mem_we;
  logic addr_src;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output addr_src,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  addr_src,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_control.sv
// Main FSM of the multi-cycle RV32I datapath: sequences fetch/decode/execute/
// memory/writeback, traps illegal opcodes and optionally stalled memory accesses.
module multicycle_control #(
  parameter bit          TRAP_ON_ILLEGAL = 1'b1,
  parameter int unsigned MEM_TIMEOUT     = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [6:0]                  opcode,
  multicycle_control_if.master        mem,
  output logic                        ir_write,
  output logic                        pc_write,
  output logic                        reg_write,
  output logic [1:0]                  result_src,
  output logic [1:0]                  alu_src_a,
  output logic [1:0]                  alu_src_b,
  output logic [1:0]                  alu_op,
  output logic                        branch,
  output logic                        retire,
  output logic                        illegal,
  output logic                        bus_err,
  output logic [3:0]                  state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LINK     = 4'd12,
    S_UPPER    = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // A zero-width counter is not legal, so a disabled watchdog keeps one idle bit.
  localparam int unsigned WD_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(MEM_TIMEOUT);

  state_t          state_r;
  state_t          state_s;
  logic [WD_W-1:0] wd_cnt_r;
  logic            illegal_r;
  logic            bus_err_r;
  logic            lui_r;
  logic            mem_state_s;
  logic            wd_expired_s;

  // Watchdog qualifiers: which states wait on memory and whether the budget is spent.
  always_comb begin
    mem_state_s  = 1'b0;
    wd_expired_s = 1'b0;
    if ((state_r == S_FETCH) || (state_r == S_MEMREAD) || (state_r == S_MEMWRITE)) begin
      mem_state_s = 1'b1;
    end else begin
      mem_state_s = 1'b0;
    end
    if ((MEM_TIMEOUT > 0) && mem_state_s && !mem.mem_ready && (wd_cnt_r == WD_MAX)) begin
      wd_expired_s = 1'b1;
    end else begin
      wd_expired_s = 1'b0;
    end
  end

  // Next-state logic; a completing memory access takes priority over the watchdog.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (mem.mem_ready) begin
          state_s = S_DECODE;
        end else if (wd_expired_s) begin
          state_s = S_TRAP;
        end else begin
          state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_s = S_MEMADR;
          OP_R:              state_s = S_EXEC_R;
          OP_I:              state_s = S_EXEC_I;
          OP_BRANCH:         state_s = S_BEQ;
          OP_JAL:            state_s = S_JAL;
          OP_JALR:           state_s = S_JALR;
          OP_LUI, OP_AUIPC:  state_s = S_UPPER;
          default: begin
            if (TRAP_ON_ILLEGAL) begin
              state_s = S_TRAP;
            end else begin
              state_s = S_FETCH;
            end
          end
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LOAD) begin
          state_s = S_MEMREAD;
        end else begin
          state_s = S_MEMWRITE;
        end
      end
      S_MEMREAD, S_MEMWRITE: begin
        if (mem.mem_ready) begin
          state_s = (state_r == S_MEMREAD) ? S_MEMWB : S_FETCH;
        end else if (wd_expired_s) begin
          state_s = S_TRAP;
        end else begin
          state_s = state_r;
        end
      end
      S_MEMWB:  state_s = S_FETCH;
      S_EXEC_R: state_s = S_ALUWB;
      S_EXEC_I: state_s = S_ALUWB;
      S_ALUWB:  state_s = S_FETCH;
      S_BEQ:    state_s = S_FETCH;
      S_JAL:    state_s = S_ALUWB;
      S_JALR:   state_s = S_LINK;
      S_LINK:   state_s = S_ALUWB;
      S_UPPER:  state_s = S_ALUWB;
      S_TRAP:   state_s = S_TRAP;
      default:  state_s = S_FETCH;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_s;
    end
  end

  // Stall counter, restarted on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_r <= {WD_W{1'b0}};
    end else if (state_s != state_r) begin
      wd_cnt_r <= {WD_W{1'b0}};
    end else if (mem_state_s && !mem.mem_ready && (wd_cnt_r != WD_MAX)) begin
      wd_cnt_r <= wd_cnt_r + {{(WD_W-1){1'b0}}, 1'b1};
    end else begin
      wd_cnt_r <= wd_cnt_r;
    end
  end

  // Trap cause captured once on entry; TRAP is only left through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_r <= 1'b0;
      bus_err_r <= 1'b0;
    end else if ((state_r != S_TRAP) && (state_s == S_TRAP)) begin
      illegal_r <= !wd_expired_s;
      bus_err_r <= wd_expired_s;
    end else begin
      illegal_r <= illegal_r;
      bus_err_r <= bus_err_r;
    end
  end

  // UPPER must not look at opcode again, so lui vs auipc is remembered from DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lui_r <= 1'b0;
    end else if (state_r == S_DECODE) begin
      lui_r <= (opcode == OP_LUI);
    end else begin
      lui_r <= lui_r;
    end
  end

  // Output decode: Moore from state_r, except the FETCH enables which follow mem_ready.
  always_comb begin
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.addr_src = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    reg_write    = 1'b0;
    result_src   = 2'b00;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;
    branch       = 1'b0;
    retire       = 1'b0;
    illegal      = 1'b0;
    bus_err      = 1'b0;
    state_o      = state_r;
    case (state_r)
      S_FETCH: begin
        mem.mem_req = 1'b1;
        alu_src_b   = 2'b10;
        result_src  = 2'b10;
        ir_write    = mem.mem_ready;
        pc_write    = mem.mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        if ((state_s == S_FETCH) && !TRAP_ON_ILLEGAL) begin
          retire = 1'b1;
        end else begin
          retire = 1'b0;
        end
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        mem.mem_req  = 1'b1;
        mem.addr_src = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        result_src = 2'b01;
        retire     = 1'b1;
      end
      S_MEMWRITE: begin
        mem.mem_req  = 1'b1;
        mem.mem_we   = 1'b1;
        mem.addr_src = 1'b1;
        retire       = mem.mem_ready;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b11;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        retire    = 1'b1;
      end
      S_JAL: begin
        pc_write  = 1'b1;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      S_JALR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = 1'b1;
      end
      S_LINK: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      S_UPPER: begin
        alu_src_a = lui_r ? 2'b11 : 2'b01;
        alu_src_b = 2'b01;
      end
      S_TRAP: begin
        illegal = illegal_r;
        bus_err = bus_err_r;
      end
      default: begin
        state_o = state_r;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench: two controller instances (trap/timeout=4 and
// nop-on-illegal/no watchdog), every cycle compared against a hand-written word.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [6:0] opc_a, opc_b;
  int         n_vec = 0;
  int         n_miss = 0;

  multicycle_control_if if_a ();
  multicycle_control_if if_b ();

  logic       irw_a, pcw_a, rw_a, br_a, ret_a, ill_a, be_a;
  logic [1:0] rs_a, sa_a, sb_a, op_a;
  logic [3:0] st_a;
  logic       irw_b, pcw_b, rw_b, br_b, ret_b, ill_b, be_b;
  logic [1:0] rs_b, sa_b, sb_b, op_b;
  logic [3:0] st_b;

  always #5 clk = ~clk;

  multicycle_control #(.TRAP_ON_ILLEGAL(1'b1), .MEM_TIMEOUT(4)) dut_a (
    .clk(clk), .rst_n(rst_a), .opcode(opc_a), .mem(if_a.master),
    .ir_write(irw_a), .pc_write(pcw_a), .reg_write(rw_a), .result_src(rs_a),
    .alu_src_a(sa_a), .alu_src_b(sb_a), .alu_op(op_a), .branch(br_a),
    .retire(ret_a), .illegal(ill_a), .bus_err(be_a), .state_o(st_a)
  );

  multicycle_control #(.TRAP_ON_ILLEGAL(1'b0), .MEM_TIMEOUT(0)) dut_b (
    .clk(clk), .rst_n(rst_b), .opcode(opc_b), .mem(if_b.master),
    .ir_write(irw_b), .pc_write(pcw_b), .reg_write(rw_b), .result_src(rs_b),
    .alu_src_a(sa_b), .alu_src_b(sb_b), .alu_op(op_b), .branch(br_b),
    .retire(ret_b), .illegal(ill_b), .bus_err(be_b), .state_o(st_b)
  );

  // Output word layout: req we asrc irw pcw rw rs[2] A[2] B[2] op[2] br ret ill be st[4]
  logic [21:0] obs_a, obs_b;
  assign obs_a = {if_a.mem_req, if_a.mem_we, if_a.addr_src, irw_a, pcw_a, rw_a,
                  rs_a, sa_a, sb_a, op_a, br_a, ret_a, ill_a, be_a, st_a};
  assign obs_b = {if_b.mem_req, if_b.mem_we, if_b.addr_src, irw_b, pcw_b, rw_b,
                  rs_b, sa_b, sb_b, op_b, br_b, ret_b, ill_b, be_b, st_b};

  function automatic logic [21:0] w(logic rq, logic we, logic as, logic irw, logic pcw,
                                    logic rw, logic [1:0] rs, logic [1:0] a, logic [1:0] b,
                                    logic [1:0] op, logic br, logic ret, logic ill,
                                    logic be, logic [3:0] st);
    return {rq, we, as, irw, pcw, rw, rs, a, b, op, br, ret, ill, be, st};
  endfunction

  localparam logic [21:0] E_FETCH_W = w(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0,4'd0);
  localparam logic [21:0] E_FETCH_G = w(1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,2'b10,2'b00,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0,4'd0);
  localparam logic [21:0] E_DECODE  = w(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,2'b00,1'b0,1'b0,1'b0,1'b0,4'd1);
  localparam logic [21:0] E_DEC_NOP = w(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,2'b00,1'b0,1'b1,1'b0,1'b0,4'd1);
  localparam logic [21:0] E_MEMADR  = w(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b00,1'b0,1'b0,1'b0,1'b0,4'd2);
  localparam logic [21:0] E_MEMRD   = w(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,4'd3);
  localparam logic [21:0] E_MEMWB   = w(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b00,2'b00,2'b00,1'b0,1'b1,1'b0,1'b0,4'd4);
  localparam logic [21:0] E_MEMWR_W = w(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,4'd5);
  localparam logic [21:0] E_MEMWR_G = w(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b1,1'b0,1'b0,4'd5);
  localparam logic [21:0] E_EXEC_R  = w(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b10,1'b0,1'b0,1'b0,1'b0,4'd6);
  localparam logic [21:0] E_EXEC_I  = w(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b11,1'b0,1'b0,1'b0,1'b0,4'd7);
  localparam logic [21:0] E_ALUWB   = w(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b0,1'b1,1'b0,1'b0,4'd8);
  localparam logic [21:0] E_BEQ     = w(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b01,1'b1,1'b1,1'b0,1'b0,4'd9);
  localparam logic [21:0] E_JAL     = w(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b01,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0,4'd10);
  localparam logic [21:0] E_JALR    = w(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b10,2'b10,2'b01,2'b00,1'b0,1'b0,1'b0,1'b0,4'd11);
  localparam logic [21:0] E_LINK    = w(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0,4'd12);
  localparam logic [21:0] E_LUI     = w(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b11,2'b01,2'b00,1'b0,1'b0,1'b0,1'b0,4'd13);
  localparam logic [21:0] E_AUIPC   = w(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,2'b00,1'b0,1'b0,1'b0,1'b0,4'd13);
  localparam logic [21:0] E_TRAP_IL = w(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b1,1'b0,4'd14);
  localparam logic [21:0] E_TRAP_BE = w(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b1,4'd14);

  localparam logic [6:0] LD = 7'b0000011, SD = 7'b0100011, RR = 7'b0110011,
                         II = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111,
                         JR = 7'b1100111, LU = 7'b0110111, AU = 7'b0010111,
                         XX = 7'b1111111;

  task automatic check_eq(input string tag, input logic [21:0] got, input logic [21:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs on the falling edge, compare 1 ns later.
  task automatic cyc(input bit sel_b, input logic rdy, input logic [6:0] op,
                     input logic [21:0] exp, input string tag);
    @(negedge clk);
    if (sel_b) begin
      rst_b = 1'b1; if_b.mem_ready = rdy; opc_b = op;
    end else begin
      rst_a = 1'b1; if_a.mem_ready = rdy; opc_a = op;
    end
    #1;
    check_eq(tag, sel_b ? obs_b : obs_a, exp);
  endtask

  task automatic do_reset(input bit sel_b, input string tag);
    @(negedge clk);
    if (sel_b) begin
      rst_b = 1'b0; if_b.mem_ready = 1'b0;
    end else begin
      rst_a = 1'b0; if_a.mem_ready = 1'b0;
    end
    #1;
    check_eq(tag, sel_b ? obs_b : obs_a, E_FETCH_W);
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; opc_a = 7'd0; opc_b = 7'd0;
    if_a.mem_ready = 1'b0; if_b.mem_ready = 1'b0;

    // R-type, zero wait: 0,1,6,8,0
    do_reset(1'b0, "reset_a");
    cyc(1'b0, 1'b1, RR, E_FETCH_G, "r_fetch");
    cyc(1'b0, 1'b1, RR, E_DECODE,  "r_decode");
    cyc(1'b0, 1'b1, RR, E_EXEC_R,  "r_exec");
    cyc(1'b0, 1'b1, RR, E_ALUWB,   "r_aluwb");
    // load, three stall cycles in MEMREAD
    cyc(1'b0, 1'b1, LD, E_FETCH_G, "ld_fetch");
    cyc(1'b0, 1'b1, LD, E_DECODE,  "ld_decode");
    cyc(1'b0, 1'b1, LD, E_MEMADR,  "ld_memadr");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, LD, E_MEMRD, "ld_stall");
    cyc(1'b0, 1'b1, LD, E_MEMRD,   "ld_ready");
    cyc(1'b0, 1'b0, LD, E_MEMWB,   "ld_memwb");
    // store
    cyc(1'b0, 1'b1, SD, E_FETCH_G, "st_fetch");
    cyc(1'b0, 1'b1, SD, E_DECODE,  "st_decode");
    cyc(1'b0, 1'b1, SD, E_MEMADR,  "st_memadr");
    cyc(1'b0, 1'b1, SD, E_MEMWR_G, "st_write");
    // beq
    cyc(1'b0, 1'b1, BQ, E_FETCH_G, "beq_fetch");
    cyc(1'b0, 1'b1, BQ, E_DECODE,  "beq_decode");
    cyc(1'b0, 1'b1, BQ, E_BEQ,     "beq_exec");
    // I-type
    cyc(1'b0, 1'b1, II, E_FETCH_G, "i_fetch");
    cyc(1'b0, 1'b1, II, E_DECODE,  "i_decode");
    cyc(1'b0, 1'b1, II, E_EXEC_I,  "i_exec");
    cyc(1'b0, 1'b1, II, E_ALUWB,   "i_aluwb");
    // lui: opcode changes after DECODE and must not affect UPPER
    cyc(1'b0, 1'b1, LU, E_FETCH_G, "lui_fetch");
    cyc(1'b0, 1'b1, LU, E_DECODE,  "lui_decode");
    cyc(1'b0, 1'b1, AU, E_LUI,     "lui_upper");
    cyc(1'b0, 1'b1, AU, E_ALUWB,   "lui_aluwb");
    cyc(1'b0, 1'b1, AU, E_FETCH_G, "auipc_fetch");
    cyc(1'b0, 1'b1, AU, E_DECODE,  "auipc_decode");
    cyc(1'b0, 1'b1, AU, E_AUIPC,   "auipc_upper");
    cyc(1'b0, 1'b1, AU, E_ALUWB,   "auipc_aluwb");
    // jalr 0,1,11,12,8 then jal 0,1,10,8
    cyc(1'b0, 1'b1, JR, E_FETCH_G, "jalr_fetch");
    cyc(1'b0, 1'b1, JR, E_DECODE,  "jalr_decode");
    cyc(1'b0, 1'b1, JR, E_JALR,    "jalr_exec");
    cyc(1'b0, 1'b1, JR, E_LINK,    "jalr_link");
    cyc(1'b0, 1'b1, JR, E_ALUWB,   "jalr_aluwb");
    cyc(1'b0, 1'b1, JL, E_FETCH_G, "jal_fetch");
    cyc(1'b0, 1'b1, JL, E_DECODE,  "jal_decode");
    cyc(1'b0, 1'b1, JL, E_JAL,     "jal_exec");
    cyc(1'b0, 1'b1, JL, E_ALUWB,   "jal_aluwb");
    cyc(1'b0, 1'b0, JL, E_FETCH_W, "jal_next");

    // mem_ready on the 5th stall cycle beats the timeout; counter restarts in MEMREAD
    do_reset(1'b0, "reset_wd_ok");
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, LD, E_FETCH_W, "wd_stall");
    cyc(1'b0, 1'b1, LD, E_FETCH_G, "wd_ready_5th");
    cyc(1'b0, 1'b0, LD, E_DECODE,  "wd_decode");
    cyc(1'b0, 1'b0, LD, E_MEMADR,  "wd_memadr");
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, LD, E_MEMRD, "wd_rd_stall");
    cyc(1'b0, 1'b1, LD, E_MEMRD,   "wd_rd_ready");
    cyc(1'b0, 1'b0, LD, E_MEMWB,   "wd_memwb");

    // mem_ready stuck low in FETCH: TRAP after 5 stall cycles
    do_reset(1'b0, "reset_wd_trap");
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, RR, E_FETCH_W, "to_stall");
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, RR, E_TRAP_BE, "to_trap");

    // illegal opcode traps and holds
    do_reset(1'b0, "reset_ill");
    cyc(1'b0, 1'b1, XX, E_FETCH_G, "ill_fetch");
    cyc(1'b0, 1'b1, XX, E_DECODE,  "ill_decode");
    for (int i = 0; i < 22; i++) cyc(1'b0, i[0], RR, E_TRAP_IL, "ill_hold");

    // asynchronous reset in the middle of a stalled store
    do_reset(1'b0, "reset_mw");
    cyc(1'b0, 1'b1, SD, E_FETCH_G, "mw_fetch");
    cyc(1'b0, 1'b1, SD, E_DECODE,  "mw_decode");
    cyc(1'b0, 1'b0, SD, E_MEMADR,  "mw_memadr");
    cyc(1'b0, 1'b0, SD, E_MEMWR_W, "mw_stall");
    #1 rst_a = 1'b0;
    #1 check_eq("mw_async_rst", obs_a, E_FETCH_W);

    // instance B: illegal retired as NOP, watchdog disabled
    do_reset(1'b1, "reset_b");
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, XX, E_FETCH_W, "b_long_stall");
    cyc(1'b1, 1'b1, XX, E_FETCH_G, "b_fetch");
    cyc(1'b1, 1'b0, XX, E_DEC_NOP, "b_nop_retire");
    cyc(1'b1, 1'b0, XX, E_FETCH_W, "b_back_fetch");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
